bayer_seq_reorder: RTL and testbench

//  Parametrised Bayer-beat to channel-sequence reorderer ahead of the LJPEG predictor/encoder.

---
 rtl/bayer_seq_pkg.sv | 23 ++
 rtl/bayer_seq_bank.sv | 37 +++
 rtl/bayer_seq_reorder.sv | 201 ++++++++++++++++++++
 tb/tb_bayer_seq_reorder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bayer_seq_pkg.sv
// Shared types and helpers for the Bayer beat reorderer (bayer_seq_reorder).
package bayer_seq_pkg;
    localparam int DEF_PIX_W        = 12;
    localparam int DEF_PIX_PER_BEAT = 16;
    localparam int DEF_BURST_BEATS  = 32;
    localparam int HALF_W           = DEF_PIX_W * DEF_PIX_PER_BEAT / 2;
    localparam int CNT_W            = $clog2(DEF_BURST_BEATS);

    typedef enum logic [1:0] { IDLE = 2'd0, LOAD = 2'd1, SHOW = 2'd2 } rd_state_e;

    function automatic int grp(input int i);
        return (i % 4) >> 1;
    endfunction

    // Slot that pixel i occupies inside its group half, ascending pixel order.
    function automatic int half_pos(input int i);
        return (i / 4) * 2 + (i % 2);
    endfunction

    function automatic int pix_of(input int g, input int k);
        return (k / 2) * 4 + g * 2 + (k % 2);
    endfunction
endpackage

// File: rtl/bayer_seq_bank.sv
// One ping/pong bank: two write ports (one per group half) and a registered
// two-address read so a whole output beat is fetched in a single LOAD cycle.
module bayer_seq_bank #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 96,
    parameter int AW    = 6
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_wa0,
    input  logic [AW-1:0]    i_wa1,
    input  logic [WIDTH-1:0] i_wd0,
    input  logic [WIDTH-1:0] i_wd1,
    input  logic             i_re,
    input  logic [AW-1:0]    i_ra0,
    input  logic [AW-1:0]    i_ra1,
    output logic [WIDTH-1:0] o_rd0,
    output logic [WIDTH-1:0] o_rd1
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd0, r_rd1;

    // The two write addresses differ in their MSB (group bit), so they never collide.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_wa0] <= i_wd0;
            r_mem[i_wa1] <= i_wd1;
        end
        if (i_re) begin
            r_rd0 <= r_mem[i_ra0];
            r_rd1 <= r_mem[i_ra1];
        end
    end

    assign o_rd0 = r_rd0;
    assign o_rd1 = r_rd1;
endmodule

// File: rtl/bayer_seq_reorder.sv
// Bayer beat -> channel-sequence reorderer with ping/pong banks and frame flush.
// Optional BAYER_SEQ_BYPASS_EN adds a per-burst `bypass` input (emit input order).
module bayer_seq_reorder
    import bayer_seq_pkg::*;
#(
    parameter int PIX_W        = 12,
    parameter int PIX_PER_BEAT = 16,
    parameter int BURST_BEATS  = 32
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic [PIX_W*PIX_PER_BEAT-1:0] in_pixels,
    input  logic                          in_valid,
    input  logic                          in_last,
    output logic                          in_ready,
`ifdef BAYER_SEQ_BYPASS_EN
    input  logic                          bypass,
`endif
    output logic [PIX_W*PIX_PER_BEAT-1:0] out_pixels,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic                          end_out
);
    localparam int BEAT_W = PIX_W * PIX_PER_BEAT;
    localparam int HW     = BEAT_W / 2;
    localparam int H      = PIX_PER_BEAT / 2;
    localparam int CW     = $clog2(BURST_BEATS);
    localparam int AW     = CW + 1;

    logic                 r_init;
    logic                 r_wr_bank;
    logic [CW-1:0]        r_wr_cnt;
    logic [1:0]           r_full;
    logic [1:0][CW-1:0]   r_nm1;
    logic [1:0]           r_lastf;
`ifdef BAYER_SEQ_BYPASS_EN
    logic [1:0]           r_byp;
`endif

    rd_state_e            r_state;
    logic                 r_rd_bank;
    logic [CW-1:0]        r_j;
    logic                 r_out_valid;
    logic                 r_out_last;
    logic                 r_end_out;

    logic                 w_in_fire;
    logic                 w_close;
    logic                 w_release;
    logic [HW-1:0]        w_g0, w_g1;
    logic [AW-1:0]        w_n, w_k0, w_k1, w_ra0, w_ra1;
    logic [CW-1:0]        w_d0, w_d1;
    logic [1:0][HW-1:0]   w_rd0, w_rd1;
    logic [HW-1:0]        w_lo, w_hi;
    logic [BEAT_W-1:0]    w_beat;

    for (genvar k = 0; k < H; k++) begin : g_split
        assign w_g0[k*PIX_W +: PIX_W] = in_pixels[pix_of(0, k)*PIX_W +: PIX_W];
        assign w_g1[k*PIX_W +: PIX_W] = in_pixels[pix_of(1, k)*PIX_W +: PIX_W];
    end

    assign in_ready  = r_init && !r_full[r_wr_bank];
    assign w_in_fire = in_valid && in_ready;
    assign w_close   = w_in_fire && ((r_wr_cnt == CW'(BURST_BEATS - 1)) || in_last);
    assign w_release = (r_state == SHOW) && out_ready && (r_j == r_nm1[r_rd_bank]);

    // Writer side; the reader only ever clears the full flag of the bank it drains.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_init    <= 1'b0;
            r_wr_bank <= 1'b0;
            r_wr_cnt  <= '0;
            r_full    <= '0;
            r_nm1     <= '0;
            r_lastf   <= '0;
`ifdef BAYER_SEQ_BYPASS_EN
            r_byp     <= '0;
`endif
        end else begin
            r_init <= 1'b1;
            if (w_in_fire) begin
                if (w_close) begin
                    r_wr_cnt           <= '0;
                    r_wr_bank          <= ~r_wr_bank;
                    r_full[r_wr_bank]  <= 1'b1;
                    r_nm1[r_wr_bank]   <= r_wr_cnt;
                    r_lastf[r_wr_bank] <= in_last;
`ifdef BAYER_SEQ_BYPASS_EN
                    r_byp[r_wr_bank]   <= bypass;
`endif
                end else begin
                    r_wr_cnt <= r_wr_cnt + 1'b1;
                end
            end
            if (w_release)
                r_full[r_rd_bank] <= 1'b0;
        end
    end

    // Stream position k maps to g0(b_k) for k<n, otherwise g1(b_(k-n)).
    always_comb begin
        w_n  = AW'(r_nm1[r_rd_bank]) + AW'(1);
        w_k0 = {r_j, 1'b0};
        w_k1 = {r_j, 1'b1};
        w_d0 = CW'(w_k0 - w_n);
        w_d1 = CW'(w_k1 - w_n);
        w_ra0 = (w_k0 < w_n) ? {1'b0, w_k0[CW-1:0]} : {1'b1, w_d0};
        w_ra1 = (w_k1 < w_n) ? {1'b0, w_k1[CW-1:0]} : {1'b1, w_d1};
`ifdef BAYER_SEQ_BYPASS_EN
        if (r_byp[r_rd_bank]) begin
            w_ra0 = {1'b0, r_j};
            w_ra1 = {1'b1, r_j};
        end
`endif
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        bayer_seq_bank #(
            .DEPTH (2 * BURST_BEATS),
            .WIDTH (HW),
            .AW    (AW)
        ) u_bank (
            .i_clk (sys_clk),
            .i_we  (w_in_fire && (r_wr_bank == 1'(b))),
            .i_wa0 ({1'b0, r_wr_cnt}),
            .i_wa1 ({1'b1, r_wr_cnt}),
            .i_wd0 (w_g0),
            .i_wd1 (w_g1),
            .i_re  ((r_state == LOAD) && (r_rd_bank == 1'(b))),
            .i_ra0 (w_ra0),
            .i_ra1 (w_ra1),
            .o_rd0 (w_rd0[b]),
            .o_rd1 (w_rd1[b])
        );
    end

    assign w_lo = w_rd0[r_rd_bank];
    assign w_hi = w_rd1[r_rd_bank];

`ifdef BAYER_SEQ_BYPASS_EN
    logic [BEAT_W-1:0] w_byp_beat;
    for (genvar i = 0; i < PIX_PER_BEAT; i++) begin : g_unsplit
        if (grp(i) == 0) begin : g_lo
            assign w_byp_beat[i*PIX_W +: PIX_W] = w_lo[half_pos(i)*PIX_W +: PIX_W];
        end else begin : g_hi
            assign w_byp_beat[i*PIX_W +: PIX_W] = w_hi[half_pos(i)*PIX_W +: PIX_W];
        end
    end
    assign w_beat = r_byp[r_rd_bank] ? w_byp_beat : {w_hi, w_lo};
`else
    assign w_beat = {w_hi, w_lo};
`endif

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state     <= IDLE;
            r_rd_bank   <= 1'b0;
            r_j         <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_end_out   <= 1'b0;
        end else begin
            r_end_out <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_full[r_rd_bank]) begin
                        r_state <= LOAD;
                        r_j     <= '0;
                    end
                end
                LOAD: begin
                    r_state     <= SHOW;
                    r_out_valid <= 1'b1;
                    r_out_last  <= (r_j == r_nm1[r_rd_bank]) && r_lastf[r_rd_bank];
                end
                SHOW: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_end_out   <= r_out_last;
                        if (r_j != r_nm1[r_rd_bank]) begin
                            r_j     <= r_j + 1'b1;
                            r_state <= LOAD;
                        end else begin
                            r_rd_bank <= ~r_rd_bank;
                            r_state   <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Gating keeps the pixel bus at 0 whenever no beat is being shown.
    assign out_pixels = r_out_valid ? w_beat : '0;
    assign out_valid  = r_out_valid;
    assign out_last   = r_out_last;
    assign end_out    = r_end_out;
endmodule

// File: tb/tb_bayer_seq_reorder.sv
// Directed + random bench for bayer_seq_reorder against a queue-based burst model.
module tb_bayer_seq_reorder;
    import bayer_seq_pkg::*;

    localparam int PW  = DEF_PIX_W;
    localparam int PPB = DEF_PIX_PER_BEAT;
    localparam int BW  = PW * PPB;
    localparam int BB  = 1 << CNT_W;

    typedef logic [BW-1:0]     beat_t;
    typedef logic [HALF_W-1:0] half_t;
    typedef struct { beat_t pix; bit last; } ent_t;

    logic  clk = 1'b0;
    logic  rst;
    beat_t in_pixels;
    logic  in_valid, in_last, in_ready;
    beat_t out_pixels;
    logic  out_valid, out_ready, out_last, end_out;
    logic  byp_drv;

    bayer_seq_reorder #(
        .PIX_W(DEF_PIX_W), .PIX_PER_BEAT(DEF_PIX_PER_BEAT), .BURST_BEATS(DEF_BURST_BEATS)
    ) dut (
        .sys_clk(clk), .sys_rst(rst),
        .in_pixels(in_pixels), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
`ifdef BAYER_SEQ_BYPASS_EN
        .bypass(byp_drv),
`endif
        .out_pixels(out_pixels), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .end_out(end_out)
    );

    always #5 clk = ~clk;

    ent_t  src_q[$];
    beat_t bur_q[$];
    ent_t  exp_q[$];
    beat_t cap[$];
    int    errs, checks, acc_cnt, end_cnt, edge_n, close_edge, first_vld_edge;
    bit    pend_end, prev_hold;
    beat_t prev_pix;

    task automatic chk(input string tag, input beat_t obs, input beat_t exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // Burst of n beats -> halves g0(b0..bn-1) then g1(b0..bn-1), paired low/high.
    function automatic void build(input bit last, input bit byp);
        half_t s[$];
        half_t h;
        beat_t b;
        ent_t  e;
        int    n, k;
        n = bur_q.size();
        for (int j = 0; j < n; j++) begin
            if (byp) e.pix = bur_q[j];
            e.last = last && (j == n - 1);
            if (byp) exp_q.push_back(e);
        end
        if (!byp) begin
            for (int g = 0; g < 2; g++)
                for (int bi = 0; bi < n; bi++) begin
                    b = bur_q[bi];
                    h = '0;
                    k = 0;
                    for (int i = 0; i < PPB; i++)
                        if (((i % 4) < 2) == (g == 0)) begin
                            h[k*PW +: PW] = b[i*PW +: PW];
                            k++;
                        end
                    s.push_back(h);
                end
            for (int j = 0; j < n; j++) begin
                e.pix  = {s[2*j+1], s[2*j]};
                e.last = last && (j == n - 1);
                exp_q.push_back(e);
            end
        end
    endfunction

    function automatic bit model_push(input beat_t p, input bit last, input bit byp);
        bur_q.push_back(p);
        if (bur_q.size() == BB || last) begin
            build(last, byp);
            bur_q.delete();
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic add_frame(input int n, input bit rnd);
        ent_t e;
        for (int b = 0; b < n; b++) begin
            for (int i = 0; i < PPB; i++)
                e.pix[i*PW +: PW] = rnd ? PW'($urandom) : PW'(b * PPB + i);
            e.last = (b == n - 1);
            src_q.push_back(e);
        end
    endtask

    task automatic cyc(input int vp, input int rp);
        ent_t e;
        @(negedge clk);
        chk_i("end_out", int'(end_out), int'(pend_end));
        if (end_out) end_cnt++;
        if (prev_hold) begin
            chk_i("hold_valid", int'(out_valid), 1);
            chk("hold_pix", out_pixels, prev_pix);
        end
        in_valid  = (src_q.size() > 0) && ($urandom_range(99) < vp);
        in_pixels = in_valid ? src_q[0].pix : beat_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        in_last   = in_valid ? src_q[0].last : 1'b0;
        out_ready = ($urandom_range(99) < rp);
        #1;
        if (in_valid && in_ready) begin
            e = src_q.pop_front();
            acc_cnt++;
            if (model_push(e.pix, e.last, byp_drv) && close_edge < 0) close_edge = edge_n + 1;
        end
        if (out_valid && first_vld_edge < 0) first_vld_edge = edge_n;
        if (out_valid && out_ready) begin
            chk_i("out_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_pix", out_pixels, e.pix);
                chk_i("out_last", int'(out_last), int'(e.last));
            end
            cap.push_back(out_pixels);
        end
        pend_end  = out_valid && out_ready && out_last;
        prev_hold = out_valid && !out_ready;
        prev_pix  = out_pixels;
        @(posedge clk);
        edge_n++;
    endtask

    task automatic drain(input int vp, input int rp, input int budget);
        int t = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0 || bur_q.size() > 0) && t < budget) begin
            cyc(vp, rp);
            t++;
        end
        chk_i("drain_done", int'(t < budget), 1);
        repeat (3) cyc(vp, 100);
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
        #1 chk_i("in_ready_pre", int'(in_ready), 0);
        @(posedge clk);
        edge_n++;
        #1 chk_i("in_ready_post", int'(in_ready), 1);
    endtask

    int    lo_l[8] = '{0, 1, 4, 5, 8, 9, 12, 13};
    int    hi_l[8] = '{2, 3, 6, 7, 10, 11, 14, 15};
    beat_t exp0, exp16;

    initial begin
        errs = 0; checks = 0; acc_cnt = 0; end_cnt = 0; edge_n = 0;
        pend_end = 0; prev_hold = 0; byp_drv = 0;
        rst = 1'b1; in_valid = 0; in_last = 0; in_pixels = '0; out_ready = 0;
        close_edge = -1; first_vld_edge = -1;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_i("rst_in_ready", int'(in_ready), 0);
        chk_i("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_pix", out_pixels, '0);
        chk_i("rst_out_last", int'(out_last), 0);
        chk_i("rst_end_out", int'(end_out), 0);
        release_rst();

        // 1: 32-beat ramp frame, out_ready held high
        for (int k = 0; k < 8; k++) begin
            exp0[k*PW +: PW]       = PW'(lo_l[k]);
            exp0[(8+k)*PW +: PW]   = PW'(16 + lo_l[k]);
            exp16[k*PW +: PW]      = PW'(hi_l[k]);
            exp16[(8+k)*PW +: PW]  = PW'(16 + hi_l[k]);
        end
        cap.delete();
        add_frame(32, 1'b0);
        drain(100, 100, 2000);
        // first out_valid is in cycle 3 when the accept cycle is cycle 0
        chk_i("latency", first_vld_edge - close_edge, 2);
        chk_i("t1_count", cap.size(), 32);
        if (cap.size() > 16) begin
            chk("t1_beat0", cap[0], exp0);
            chk("t1_beat16", cap[16], exp16);
        end

        // 2: short 5-beat frame, then a full frame
        cap.delete(); end_cnt = 0;
        add_frame(5, 1'b1);
        drain(100, 100, 2000);
        chk_i("t2_count", cap.size(), 5);
        chk_i("t2_end_cnt", end_cnt, 1);
        cap.delete();
        add_frame(32, 1'b1);
        drain(100, 100, 2000);
        chk_i("t2b_count", cap.size(), 32);

        // 3: stalled consumer, both banks fill
        acc_cnt = 0; cap.delete();
        add_frame(96, 1'b1);
        repeat (100) cyc(100, 0);
        #1;
        chk_i("t3_accepted", acc_cnt, 64);
        chk_i("t3_in_ready", int'(in_ready), 0);
        drain(100, 100, 2000);
        chk_i("t3_count", cap.size(), 96);

        // 4: random handshakes, 10 frames of random length
        cap.delete();
        for (int f = 0; f < 10; f++) add_frame(int'($urandom_range(100, 1)), 1'b1);
        drain(50, 50, 20000);

        // 5: reset while beat 7 is being drained
        cap.delete();
        add_frame(32, 1'b1);
        begin
            int t = 0;
            while (cap.size() < 7 && t < 500) begin cyc(100, 100); t++; end
            chk_i("t5_reach7", int'(t < 500), 1);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk_i("t5_out_valid", int'(out_valid), 0);
        chk("t5_out_pix", out_pixels, '0);
        chk_i("t5_out_last", int'(out_last), 0);
        chk_i("t5_in_ready", int'(in_ready), 0);
        src_q.delete(); bur_q.delete(); exp_q.delete();
        pend_end = 0; prev_hold = 0; in_valid = 0; out_ready = 0;
        release_rst();
        cap.delete();
        add_frame(32, 1'b1);
        drain(100, 100, 2000);
        chk_i("t5_count", cap.size(), 32);

`ifdef BAYER_SEQ_BYPASS_EN
        // 6: bypass burst then reordered burst
        cap.delete();
        byp_drv = 1'b1;
        add_frame(32, 1'b1);
        drain(100, 100, 2000);
        byp_drv = 1'b0;
        add_frame(32, 1'b1);
        drain(100, 100, 2000);
        chk_i("t6_count", cap.size(), 64);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
